// File: rtl/kernel_loader.sv
// Unpacks 4-weight beats from a valid/ready stream into sequential kernel register writes.
// Optional KERNEL_LOADER_CHECKSUM_EN adds a 16-bit running sum of the written weights.
module kernel_loader #(
  parameter int KERNEL_REG_SIZE   = 64,
  parameter int KERNEL_ADDR_WIDTH = 6,
  parameter int WEIGHT_WIDTH      = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          start,
  input  logic [KERNEL_ADDR_WIDTH:0]    num_weights,
  input  logic                          s_valid,
  input  logic [4*WEIGHT_WIDTH-1:0]     s_data,
  output logic                          s_ready,
  output logic                          wr_en,
  output logic [KERNEL_ADDR_WIDTH-1:0]  wr_addr,
  output logic [WEIGHT_WIDTH-1:0]       wr_data,
  output logic                          busy,
  output logic                          done
`ifdef KERNEL_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                   checksum
`endif
);

  // state | meaning
  // IDLE  | waiting for start; count latched and clamped on acceptance
  // FETCH | s_ready high, waiting for the next beat
  // WRITE | one lane per cycle to the kernel register
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  localparam int AW = KERNEL_ADDR_WIDTH;
  localparam logic [AW:0]   MAX_N    = (AW+1)'(KERNEL_REG_SIZE);
  localparam logic [AW:0]   N_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t                    state;
  logic [AW:0]               n_q;
  logic [AW-1:0]             addr_q;
  logic [1:0]                lane_q;
  logic [4*WEIGHT_WIDTH-1:0] beat_q;
  logic [AW:0]               n_sel;
  logic                      last_wr;

  assign n_sel   = (num_weights > MAX_N) ? MAX_N : num_weights;
  assign last_wr = ({1'b0, addr_q} == (n_q - N_ONE));

  assign s_ready = (state == FETCH);
  assign wr_en   = (state == WRITE);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign wr_addr = addr_q;
  // The beat shifts down one lane per write, so lane 0 of beat_q is always the current weight.
  assign wr_data = beat_q[WEIGHT_WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state  <= IDLE;
      n_q    <= '0;
      addr_q <= '0;
      lane_q <= '0;
      beat_q <= '0;
`ifdef KERNEL_LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_q    <= n_sel;
            addr_q <= '0;
            lane_q <= '0;
            state  <= (n_sel == '0) ? DONE : FETCH;
`ifdef KERNEL_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        FETCH: begin
          if (s_valid) begin
            beat_q <= s_data;
            lane_q <= '0;
            state  <= WRITE;
          end
        end
        WRITE: begin
          addr_q <= addr_q + ADDR_ONE;
          lane_q <= lane_q + 2'd1;
          beat_q <= beat_q >> WEIGHT_WIDTH;
`ifdef KERNEL_LOADER_CHECKSUM_EN
          checksum <= checksum + 16'(beat_q[WEIGHT_WIDTH-1:0]);
`endif
          // Remaining lanes of a short final beat are simply dropped here.
          if (last_wr)
            state <= DONE;
          else if (lane_q == 2'd3)
            state <= FETCH;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
